camera_controller: RTL

- Produces the camera state that the map renderer consumes: `camera_y` (current level index, displayed as level number `camera_y+1`) and `camera_offset` (scroll-transition progress).
- Tracks the player's world height. When the player leaves the current level band, it runs a frame-paced scroll transition, one level per transition.
- Sits between the physics block (source of `player_y`) and the map/render path (consumer of `camera_y`, `camera_offset` and `camera_base_y`).

---
 rtl/camera_pkg.sv | 23 ++
 rtl/camera_controller.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/camera_pkg.sv
// ---------------------------------------------------------------------------
// camera_pkg
// Shared definitions for the camera controller and the map renderer.
//   - camera_state_t : controller FSM states (IDLE, SCROLL)
//   - DIR_UP/DIR_DOWN: encoding of scroll_dir
//   - DEFAULT_LEVEL_HEIGHT / DEFAULT_SCROLL_FRAMES : level band height in
//     world pixels and frames per scroll transition; the renderer relies on
//     the same values so both sides agree on the level geometry.
// ---------------------------------------------------------------------------
package camera_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        SCROLL = 1'b1
    } camera_state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int DEFAULT_LEVEL_HEIGHT  = 480;
    localparam int DEFAULT_SCROLL_FRAMES = 32;

endpackage

// File: rtl/camera_controller.sv
// ---------------------------------------------------------------------------
// camera_controller
// Follows the player's world height one level band at a time and produces
// the camera state consumed by the map renderer.
//
// Ports:
//   clk           in   system clock
//   rst           in   asynchronous, active-high reset
//   frame_tick    in   one-cycle pulse per video frame; all camera state
//                      advances only on edges where this is high
//   player_y      in   player world y (0 = floor, grows upward)
//   camera_y      out  current level index
//   camera_offset out  scroll-transition progress, 0..SCROLL_FRAMES-1
//   camera_base_y out  world y of the current level floor (camera_y*LEVEL_HEIGHT)
//   scrolling     out  high while a transition is in progress
//   scroll_dir    out  1 = up, 0 = down; meaningful while scrolling
//   level_changed out  one-cycle pulse in the cycle a new camera_y appears
//
// Build option:
//   CAMERA_INSTANT_EN - when defined, level changes take effect on the
//   qualifying frame tick with no scroll animation; camera_offset,
//   scrolling and scroll_dir then stay at 0.
// ---------------------------------------------------------------------------
import camera_pkg::*;

module camera_controller #(
    parameter int PHY_WIDTH     = 16,
    parameter int CAMERA_WIDTH  = 6,
    parameter int LEVEL_HEIGHT  = DEFAULT_LEVEL_HEIGHT,
    parameter int SCROLL_FRAMES = DEFAULT_SCROLL_FRAMES
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    frame_tick,
    input  logic [PHY_WIDTH-1:0]    player_y,
    output logic [CAMERA_WIDTH-1:0] camera_y,
    output logic [CAMERA_WIDTH-1:0] camera_offset,
    output logic [PHY_WIDTH-1:0]    camera_base_y,
    output logic                    scrolling,
    output logic                    scroll_dir,
    output logic                    level_changed
);

    localparam logic [CAMERA_WIDTH-1:0] TOP_LEVEL    = '1;
    localparam logic [PHY_WIDTH-1:0]    LEVEL_STEP   = PHY_WIDTH'(LEVEL_HEIGHT);
    localparam logic [PHY_WIDTH:0]      LEVEL_STEP_W = (PHY_WIDTH+1)'(LEVEL_HEIGHT);
`ifndef CAMERA_INSTANT_EN
    localparam logic [CAMERA_WIDTH-1:0] LAST_OFFSET  = CAMERA_WIDTH'(SCROLL_FRAMES - 1);
`endif

    camera_state_t             state, state_next;
    logic [CAMERA_WIDTH-1:0]   camera_y_next;
    logic [CAMERA_WIDTH-1:0]   camera_offset_next;
    logic [PHY_WIDTH-1:0]      camera_base_y_next;
    logic                      scroll_dir_next;
    logic                      level_changed_next;

    logic [PHY_WIDTH:0]        upper_bound;
    logic                      want_up;
    logic                      want_down;

    // Band-exit detection. The top of the band is formed one bit wider so
    // that the highest levels cannot wrap around and look like a low bound.
    // Both directions are evaluated together; up wins if both ever hold.
    always_comb begin
        upper_bound = {1'b0, camera_base_y} + LEVEL_STEP_W;
        want_up     = ({1'b0, player_y} >= upper_bound) && (camera_y != TOP_LEVEL);
        want_down   = (player_y < camera_base_y) && (camera_y != '0);
    end

    // State register and camera registers. Everything other than the
    // level_changed pulse only moves on frame ticks; that gating lives in
    // the next-state logic below.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            camera_y      <= '0;
            camera_offset <= '0;
            camera_base_y <= '0;
            scroll_dir    <= DIR_DOWN;
            level_changed <= 1'b0;
        end else begin
            state         <= state_next;
            camera_y      <= camera_y_next;
            camera_offset <= camera_offset_next;
            camera_base_y <= camera_base_y_next;
            scroll_dir    <= scroll_dir_next;
            level_changed <= level_changed_next;
        end
    end

    // Next-state logic. The floor height is tracked with an add/subtract of
    // one band per level change so no multiplier is needed.
    always_comb begin
        state_next         = state;
        camera_y_next      = camera_y;
        camera_offset_next = camera_offset;
        camera_base_y_next = camera_base_y;
        scroll_dir_next    = scroll_dir;
        level_changed_next = 1'b0;

`ifdef CAMERA_INSTANT_EN
        // No animation: the FSM never leaves IDLE and the level moves on
        // the qualifying tick itself.
        state_next         = IDLE;
        camera_offset_next = '0;
        scroll_dir_next    = DIR_DOWN;
        if (frame_tick) begin
            if (want_up) begin
                camera_y_next      = camera_y + 1'b1;
                camera_base_y_next = camera_base_y + LEVEL_STEP;
                level_changed_next = 1'b1;
            end else if (want_down) begin
                camera_y_next      = camera_y - 1'b1;
                camera_base_y_next = camera_base_y - LEVEL_STEP;
                level_changed_next = 1'b1;
            end
        end
`else
        case (state)
            IDLE: begin
                if (frame_tick) begin
                    if (want_up) begin
                        state_next         = SCROLL;
                        scroll_dir_next    = DIR_UP;
                        camera_offset_next = '0;
                    end else if (want_down) begin
                        state_next         = SCROLL;
                        scroll_dir_next    = DIR_DOWN;
                        camera_offset_next = '0;
                    end
                end
            end

            // player_y is deliberately ignored here; a multi-level move is
            // picked up again in IDLE on the next tick.
            SCROLL: begin
                if (frame_tick) begin
                    if (camera_offset == LAST_OFFSET) begin
                        state_next         = IDLE;
                        camera_offset_next = '0;
                        level_changed_next = 1'b1;
                        if (scroll_dir == DIR_UP) begin
                            camera_y_next      = camera_y + 1'b1;
                            camera_base_y_next = camera_base_y + LEVEL_STEP;
                        end else begin
                            camera_y_next      = camera_y - 1'b1;
                            camera_base_y_next = camera_base_y - LEVEL_STEP;
                        end
                    end else begin
                        camera_offset_next = camera_offset + 1'b1;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
`endif
    end

    // In the instant build state is held at IDLE, so this is constant 0.
    assign scrolling = (state == SCROLL);

endmodule
